// File: rtl/dmem_reader_pkg.sv
// Shared types and default widths for the DMem result reader.
// Optional feature macro: DMEM_READER_CHECKSUM_EN (adds a trailing checksum byte).
package dmem_reader_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
`ifdef DMEM_READER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_FIN
  } rd_state_t;

endpackage

// File: rtl/dmem_reader.sv
// Post-run DMem reader: once start (core done) is seen, sweeps START_ADDR..END_ADDR
// through a dedicated read port and streams each byte on a valid/ready interface.
// Optional feature macro: DMEM_READER_CHECKSUM_EN appends a modular-sum byte that
// carries m_last instead of the final data byte.
module dmem_reader
  import dmem_reader_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              finished
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

  // An inverted range would never reach END_ADDR without wrapping.
  if (END_ADDR < START_ADDR) begin : g_range_err
    $error("dmem_reader: END_ADDR must not be below START_ADDR");
  end

  rd_state_t         state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_last_q;
  logic              hs;
`ifdef DMEM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  assign hs = m_valid_q && m_ready;

  // Sweep FSM with address counter, registered output byte and optional checksum.
  // The END_ADDR compare happens before any increment, so END_ADDR = 2**ADDR_W-1
  // never wraps the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= START_A;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
`ifdef DMEM_READER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          // start is a level: holding it high in FIN replays the sweep
          if (start) begin
            rd_addr_q <= START_A;
`ifdef DMEM_READER_CHECKSUM_EN
            csum_q    <= '0;
`endif
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // rd_data has settled for rd_addr_q by now
          m_data_q  <= rd_data;
          m_valid_q <= 1'b1;
`ifdef DMEM_READER_CHECKSUM_EN
          m_last_q  <= 1'b0;
`else
          m_last_q  <= (rd_addr_q == END_A);
`endif
          state_q   <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
`ifdef DMEM_READER_CHECKSUM_EN
            csum_q    <= csum_q + m_data_q;
`endif
            if (rd_addr_q == END_A) begin
`ifdef DMEM_READER_CHECKSUM_EN
              // present the final sum straight away, it closes the stream
              m_data_q  <= csum_q + m_data_q;
              m_valid_q <= 1'b1;
              m_last_q  <= 1'b1;
              state_q   <= ST_CSUM;
`else
              state_q   <= ST_FIN;
`endif
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
              state_q   <= ST_FETCH;
            end
          end
        end
`ifdef DMEM_READER_CHECKSUM_EN
        ST_CSUM: begin
          if (hs) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            state_q   <= ST_FIN;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_addr  = rd_addr_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign finished = (state_q == ST_FIN);
`ifdef DMEM_READER_CHECKSUM_EN
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_SEND);
`endif

endmodule

// File: tb/tb_dmem_reader.sv
// Directed bench for dmem_reader: scoreboard of expected bytes filled per sweep,
// drained by a handshake monitor. Honours DMEM_READER_CHECKSUM_EN.
module tb_dmem_reader;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef DMEM_READER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start, m_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;
  logic          m_valid, m_last, busy, finished;

  logic          start1, m_ready1;
  logic [AW-1:0] rd_addr1;
  logic [DW-1:0] rd_data1, m_data1;
  logic          m_valid1, m_last1, busy1, finished1;

  logic [DW-1:0] mem [0:255];
  assign rd_data  = mem[rd_addr];
  assign rd_data1 = mem[rd_addr1];

  dmem_reader #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(0), .END_ADDR(3)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .finished(finished));

  dmem_reader #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(255), .END_ADDR(255)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1),
    .busy(busy1), .finished(finished1));

  int checks = 0;
  int errors = 0;
  int last_cnt = 0;
  logic [DW:0] exp_q [$];
  logic [DW:0] e;
  logic        hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change 2 time units after the rising edge, well away from both edges
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // expected stream of one sweep over addresses 0..3
  task automatic push_sweep();
    logic [DW-1:0] s;
    s = '0;
    for (int a = 0; a < 4; a++) begin
      s = s + mem[a];
      exp_q.push_back({(a == 3) && !CSUM_EN, mem[a]});
    end
    if (CSUM_EN) exp_q.push_back({1'b1, s});
  endtask

  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (finished) break;
      step(1);
    end
    chk({tag, "_finished"}, finished, 1);
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_fin_addr"}, rd_addr, 3);
  endtask

  task automatic wait_addr_valid(input logic [AW-1:0] a);
    for (int i = 0; i < 50; i++) begin
      if (m_valid && rd_addr == a) break;
      step(1);
    end
  endtask

  // handshake monitor and hold checker, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e[DW-1:0]);
          chk("m_last", m_last, e[DW]);
        end
        if (m_last) last_cnt++;
      end
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int base;
    start = 1'b0; m_ready = 1'b0; start1 = 1'b0; m_ready1 = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[255] = 8'hA5;

    // reset state
    step(2);
    chk("rst_addr", rd_addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fin", finished, 0);
    chk("rst_addr1", rd_addr1, 8'hFF);
    reset = 1'b1;
    step(1);

    // 1: basic sweep, latency of first valid
    push_sweep();
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_k_valid", m_valid, 0);
    chk("lat_k_busy", busy, 1);
    @(posedge clk); #1;
    chk("lat_k1_valid", m_valid, 1);
    @(posedge clk); #1;
    #1;
    wait_fin("t1");
    chk("t1_last_cnt", last_cnt, 1);

    // 2: backpressure on byte 22
    push_sweep();
    kick();
    wait_addr_valid(8'd1);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_addr", rd_addr, 1);
      chk("bp_data", m_data, 8'h22);
    end
    m_ready = 1'b1;
    wait_fin("t2");

    // 3: wrapping checksum data with random backpressure
    mem[0] = 8'hFF; mem[1] = 8'h02; mem[2] = 8'h00; mem[3] = 8'h00;
    push_sweep();
    kick();
    for (int i = 0; i < 200; i++) begin
      if (finished) break;
      m_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    m_ready = 1'b1;
    wait_fin("t3");

    // 4: single-byte sweep at the top address
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid1) break;
    end
    chk("t4_valid", m_valid1, 1);
    chk("t4_data", m_data1, 8'hA5);
    chk("t4_last", m_last1, !CSUM_EN);
    step(1);
    for (int i = 0; i < 10; i++) begin
      if (finished1) break;
      step(1);
    end
    chk("t4_fin", finished1, 1);
    chk("t4_busy", busy1, 0);
    chk("t4_addr", rd_addr1, 8'hFF);

    // 5: async reset in the middle of a sweep, then replay from the start
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    push_sweep();
    kick();
    wait_addr_valid(8'd2);
    m_ready = 1'b0;
    step(1);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_valid", m_valid, 0);
    chk("ar_data", m_data, 0);
    chk("ar_last", m_last, 0);
    chk("ar_busy", busy, 0);
    chk("ar_fin", finished, 0);
    chk("ar_addr", rd_addr, 0);
    exp_q.delete();
    step(2);
    reset = 1'b1;
    m_ready = 1'b1;
    step(1);
    push_sweep();
    kick();
    wait_fin("t5");

    // 6a: start pulsed while a byte is stalled is ignored
    push_sweep();
    kick();
    wait_addr_valid(8'd1);
    m_ready = 1'b0;
    start = 1'b1;
    step(3);
    chk("t6_addr", rd_addr, 1);
    chk("t6_busy", busy, 1);
    start = 1'b0;
    m_ready = 1'b1;
    wait_fin("t6a");

    // 6b: start held through FIN replays an identical sweep
    base = last_cnt;
    push_sweep();
    push_sweep();
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (last_cnt >= base + 2) break;
      step(1);
    end
    start = 1'b0;
    chk("t6_sweeps", last_cnt, base + 2);
    step(2);
    wait_fin("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
